// File: rtl/piradip_axis_pkg.sv
// ---------------------------------------------------------------------------
// piradip_axis_pkg
//   Shared declarations for the piradip AXI4-Stream blocks.
//   - framer_state_t : capture state of piradip_axis_sample_framer
//   - FRAMER_COUNT_W : width of the framer's statistics counters
//   - SKID_DEPTH     : number of storage entries behind a skid output register
// ---------------------------------------------------------------------------
package piradip_axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } framer_state_t;

    localparam int FRAMER_COUNT_W = 32;
    localparam int SKID_DEPTH     = 2;

endpackage

// File: rtl/axi4s.sv
// ---------------------------------------------------------------------------
// axi4s
//   Minimal AXI4-Stream bundle (tvalid/tready/tdata/tstrb/tlast).
//   Handshake: a beat transfers on a rising clock edge where tvalid and
//   tready are both high; once tvalid is raised the manager holds tvalid,
//   tdata, tstrb and tlast stable until that transfer happens.
//   Modports: MANAGER drives the payload, SUBORDINATE drives tready.
// ---------------------------------------------------------------------------
interface axi4s #(
    parameter int DATA_WIDTH = 32
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;

    function automatic int data_width();
        return DATA_WIDTH;
    endfunction

    modport MANAGER     (output tvalid, tdata, tstrb, tlast, input tready, import data_width);
    modport SUBORDINATE (input tvalid, tdata, tstrb, tlast, output tready, import data_width);
endinterface

// File: rtl/piradip_axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// piradip_axis_skid_buffer
//   Register slice with a registered output stage and a 2-entry skid FIFO
//   behind it. in_ready depends only on the FIFO fill level, so there is no
//   combinational path from out_ready to in_ready or out_valid. A single
//   stalled output cycle parks one beat in the FIFO while in_ready stays
//   high, so a one-cycle downstream stall never stalls the input.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     flush                 synchronous drop of every stored beat
//     in_valid/in_ready     input handshake, in_data + in_last payload
//     out_valid/out_ready   output handshake, out_data + out_last payload
//     empty                 no beat stored anywhere (output stage included)
// ---------------------------------------------------------------------------
module piradip_axis_skid_buffer
    import piradip_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  empty
);

    // Entries are stored as {last, data}; e0 is the FIFO head.
    logic [DATA_WIDTH:0] e0;
    logic [DATA_WIDTH:0] e1;
    logic [1:0]          cnt;

    logic in_fire;
    logic out_load;
    logic pop;
    logic push;

    assign in_ready = (cnt != 2'(SKID_DEPTH));
    assign in_fire  = in_valid && in_ready;
    assign out_load = !out_valid || out_ready;
    // The output stage refills from the FIFO head first to keep order.
    assign pop      = out_load && (cnt != 2'd0);
    // A beat bypasses the FIFO only when the FIFO is empty and the output stage is free.
    assign push     = in_fire && !(out_load && (cnt == 2'd0));
    assign empty    = !out_valid && (cnt == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            e0        <= '0;
            e1        <= '0;
            cnt       <= 2'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= 2'd0;
        end else begin
            if (out_load) begin
                if (cnt != 2'd0) begin
                    out_valid <= 1'b1;
                    {out_last, out_data} <= e0;
                end else if (in_fire) begin
                    out_valid <= 1'b1;
                    {out_last, out_data} <= {in_last, in_data};
                end else begin
                    out_valid <= 1'b0;
                end
            end

            if (pop && push) begin
                if (cnt == 2'd1) begin
                    e0 <= {in_last, in_data};
                end else begin
                    e0 <= e1;
                    e1 <= {in_last, in_data};
                end
            end else if (pop) begin
                e0  <= e1;
                cnt <= cnt - 2'd1;
            end else if (push) begin
                if (cnt == 2'd0) begin
                    e0 <= {in_last, in_data};
                end else begin
                    e1 <= {in_last, in_data};
                end
                cnt <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/piradip_axis_sample_framer.sv
// ---------------------------------------------------------------------------
// piradip_axis_sample_framer
//   Cuts the interleaved IQ beat stream into fixed-length frames with tlast.
//   A start pulse (frame_len != 0) arms a capture of num_frames frames
//   (0 = continuous); stop ends the capture on a frame boundary. Beats that
//   arrive while idle are accepted and thrown away so upstream never stalls.
//   Optional feature macro: PIRADIP_SAMPLE_FRAMER_DROP_COUNT_EN adds the
//   drop_count port (saturating count of beats discarded while idle).
//   Ports:
//     aclk, areset          clock, asynchronous active-high reset
//     s_in                  interleaved IQ input stream
//     m_out                 framed output stream, tlast on last beat of frame
//     frame_len, num_frames capture controls, latched on an accepted start
//     start, stop           one-cycle arm / end-at-boundary pulses
//     busy                  capture in progress (RUN or DRAIN)
//     frames_done           frames completed since reset, wraps
//     drop_count            idle beats discarded (macro builds only)
//     state_dbg             current capture state
// ---------------------------------------------------------------------------
module piradip_axis_sample_framer
    import piradip_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    axi4s.SUBORDINATE                 s_in,
    axi4s.MANAGER                     m_out,
    input  logic [LEN_W-1:0]          frame_len,
    input  logic [LEN_W-1:0]          num_frames,
    input  logic                      start,
    input  logic                      stop,
    output logic                      busy,
    output logic [FRAMER_COUNT_W-1:0] frames_done,
`ifdef PIRADIP_SAMPLE_FRAMER_DROP_COUNT_EN
    output logic [FRAMER_COUNT_W-1:0] drop_count,
`endif
    output framer_state_t             state_dbg
);

    framer_state_t state;
    framer_state_t state_nx;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] num_q;
    // Input-side position: beats of the current frame already taken into the buffer.
    logic [LEN_W-1:0] in_cnt;
    logic [LEN_W-1:0] in_frames;
    // Output-side frames completed in this capture.
    logic [LEN_W-1:0] cap_frames;
    // Input side may still take beats for this capture.
    logic             in_open;

    logic buf_in_ready;
    logic buf_empty;
    logic acc_in;
    logic in_last;
    logic start_ok;
    logic out_fire;
    logic out_last_fire;
    logic count_done;
    logic stop_eff;
    logic close_in;
    logic flush;

    assign start_ok      = (state == IDLE) && start && (frame_len != '0);
    assign acc_in        = (state != IDLE) && in_open && buf_in_ready && s_in.tvalid;
    assign in_last       = (in_cnt == len_q - 1'b1);
    assign out_fire      = m_out.tvalid && m_out.tready;
    assign out_last_fire = out_fire && m_out.tlast;
    assign count_done    = out_last_fire && (num_q != '0) && (cap_frames + 1'b1 == num_q);

    // DRAIN is only ever entered through stop, so it keeps the stop request alive.
    assign stop_eff = (state == DRAIN) || ((state == RUN) && stop);

    // The input side closes once the final beat of its frame is taken (count
    // reached or stop pending), or immediately if stop lands on a boundary.
    assign close_in = in_open &&
                      ((acc_in && in_last &&
                        (((num_q != '0) && (in_frames + 1'b1 == num_q)) || stop_eff)) ||
                       (stop_eff && !acc_in && (in_cnt == '0)));

    // Idle always accepts (and discards); a capture accepts only while open.
    assign s_in.tready = (state == IDLE) || (in_open && buf_in_ready);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (stop || count_done) begin
                    state_nx = out_last_fire ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                // Second term covers a stop with nothing in flight at a boundary.
                if (out_last_fire || (!in_open && buf_empty)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Beats of a following frame already buffered are dropped on the way to idle.
    assign flush = (state != IDLE) && (state_nx == IDLE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            len_q       <= '0;
            num_q       <= '0;
            in_cnt      <= '0;
            in_frames   <= '0;
            cap_frames  <= '0;
            in_open     <= 1'b0;
            frames_done <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                len_q      <= frame_len;
                num_q      <= num_frames;
                in_cnt     <= '0;
                in_frames  <= '0;
                cap_frames <= '0;
                in_open    <= 1'b1;
            end else begin
                if (acc_in) begin
                    if (in_last) begin
                        in_cnt    <= '0;
                        in_frames <= in_frames + 1'b1;
                    end else begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                end
                if (out_last_fire) begin
                    cap_frames <= cap_frames + 1'b1;
                end
                if (close_in || (state_nx == IDLE)) begin
                    in_open <= 1'b0;
                end
            end
            if (out_last_fire) begin
                frames_done <= frames_done + 1'b1;
            end
        end
    end

    piradip_axis_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (aclk),
        .rst       (areset),
        .flush     (flush),
        .in_valid  (acc_in),
        .in_ready  (buf_in_ready),
        .in_data   (s_in.tdata),
        .in_last   (in_last),
        .out_valid (m_out.tvalid),
        .out_ready (m_out.tready),
        .out_data  (m_out.tdata),
        .out_last  (m_out.tlast),
        .empty     (buf_empty)
    );

    // All strobes set on every presented beat, zero while nothing is presented.
    assign m_out.tstrb = {(DATA_WIDTH/8){m_out.tvalid}};
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

`ifdef PIRADIP_SAMPLE_FRAMER_DROP_COUNT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_count <= '0;
        end else if ((state == IDLE) && s_in.tvalid && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/piradip_axis_sample_framer.md
# piradip_axis_sample_framer

Downstream stage of the I/Q sample interleaver: consumes the interleaved AXI4-Stream IQ beats and cuts them into fixed-length frames with `tlast` for the DMA engine. Capture is armed by a start pulse, runs for a programmed number of frames (or continuously), and stops cleanly on a frame boundary. Beats arriving while not capturing are discarded so the upstream interleaver never stalls.

## Interface
Parameters:
- `DATA_WIDTH`, 32: beat width in bits; must equal both stream interfaces' `data_width()`.
- `LEN_W`, 16: width of the frame-length and frame-count controls.

Ports:
- `aclk`  in  1  sole clock; both stream interfaces are synchronous to it.
- `areset`  in  1  asynchronous, active-high reset.
- `s_in`  axi4s.SUBORDINATE  DATA_WIDTH  interleaved IQ input.
- `m_out`  axi4s.MANAGER  DATA_WIDTH  framed output, `tlast` on the final beat of each frame.
- `frame_len`  in  LEN_W  beats per frame; sampled on an accepted `start`.
- `num_frames`  in  LEN_W  frames per capture, 0 = continuous; sampled on an accepted `start`.
- `start`  in  1  one-cycle arm pulse.
- `stop`  in  1  one-cycle request to end the capture at the next frame boundary.
- `busy`  out  1  high in RUN or DRAIN.
- `frames_done`  out  32  frames completed since reset; wraps at 2^32.
- `drop_count`  out  32  beats discarded while idle. Present only with the macro; see Configuration.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `s_in.tready` = 1.
  - Accepted input beats are discarded.
  - `start` with `frame_len` ≠ 0: latch `frame_len` and `num_frames`, clear the beat and frame-in-capture counters, go to RUN.
  - `start` with `frame_len` = 0 is ignored.
- RUN: input passes through a 2-entry skid buffer to `m_out`. `s_in.tready` = skid buffer not full.
- Beat counter increments on each output handshake (`m_out.tvalid & m_out.tready`).
  - `m_out.tlast` = (beat counter == latched len − 1).
  - On a `tlast` handshake: beat counter → 0, `frames_done` +1, frame-in-capture counter +1.
- Leaving RUN:
  - `stop` pulse, or frame-in-capture counter reaching `num_frames` (when `num_frames` ≠ 0): go to DRAIN.
  - If this happens on the cycle of a `tlast` handshake, go directly to IDLE.
- DRAIN:
  - `s_in.tready` continues only until the last beat of the current frame has been accepted into the skid buffer. After that, `s_in.tready` = 0.
  - Go to IDLE after the `tlast` handshake on `m_out`.
  - Partial frames are never emitted.
- Protocol rules:
  - `m_out.tstrb` is all ones on every beat.
  - `m_out.tdata` and `tlast` hold stable while `tvalid & !tready`.
  - `start` in RUN or DRAIN is ignored.
  - `stop` in IDLE or DRAIN is ignored.

## Timing
- Reset values: state IDLE, `m_out.tvalid` 0, `m_out.tdata` 0, `m_out.tlast` 0, `m_out.tstrb` 0, `busy` 0, `frames_done` 0, `drop_count` 0, skid buffer empty.
- Latency: `start` seen at edge N → RUN from N+1. The first beat accepted at an edge ≥ N+1 appears on `m_out` at the next edge.
- Throughput: one beat/cycle sustained while `m_out.tready` = 1. `m_out.tready` deasserting for one cycle causes no input bubble.
- All outputs are registered; no combinational path from `m_out.tready` to `m_out.tvalid`.
- Simultaneous `start` and `stop` in IDLE: start wins; stop is ignored.
- `areset` mid-frame: output drops immediately, the partial frame is lost, counters clear, and the block returns to IDLE.

## Configuration
- Macro: `PIRADIP_SAMPLE_FRAMER_DROP_COUNT_EN`.
- Defined: the `drop_count` port and its counter exist. The counter increments on every discarded IDLE beat and saturates at 2^32 − 1.
- Undefined: the port and counter are removed; IDLE beats are discarded silently.

## Structure
- Shared package `piradip_axis_pkg` holds:
  - the state enum `framer_state_t` (IDLE, RUN, DRAIN);
  - the constant `FRAMER_COUNT_W` = 32.
- One sub-module: `piradip_axis_skid_buffer`, a 2-entry register slice parameterised by DATA_WIDTH plus a `last` bit, reusable by other stream blocks.

## Test plan
- Reset, `start`, `frame_len`=4, `num_frames`=2, continuous valid input 0,1,2,… → 8 beats out, `tlast` on 3 and 7, `frames_done`=2, back to IDLE, `busy`=0.
- `frame_len`=5, `num_frames`=0, random `m_out.tready` 50 % → no lost or duplicated beats, `tlast` every 5th beat, data stable under backpressure.
- `stop` on the 3rd beat of a 4-beat frame → frame completes with `tlast` on the 4th beat, then `s_in.tready`=0 until IDLE.
- 10 valid beats in IDLE with the macro defined → `drop_count`=10 and `m_out.tvalid` never 1. Without the macro → no `drop_count` port.
- `start` with `frame_len`=0 → stays IDLE, `busy`=0.
- `areset` pulse mid-frame → `m_out.tvalid`=0 and `frames_done`=0 the same cycle; a new `start` then produces a full clean frame.
